// File: rtl/vga_pattern_sched_if.sv
// Control/status bundle between the VGA front end and the pattern scheduler.
// The master drives frame timing and user requests; the slave reports pattern/blanking state.
interface vga_pattern_sched_if #(
  parameter int PW = 2
);
  logic          frame_start;
  logic          btn_next;
  logic          btn_mono;
  logic          auto_en;
  logic [PW-1:0] pattern;
  logic          mono;
  logic          gen_rst;
  logic          blank;
  logic          busy;

  modport master (
    output frame_start, btn_next, btn_mono, auto_en,
    input  pattern, mono, gen_rst, blank, busy
  );

  modport slave (
    input  frame_start, btn_next, btn_mono, auto_en,
    output pattern, mono, gen_rst, blank, busy
  );
endinterface

// File: rtl/vga_pattern_sched.sv
// Frame-synchronous test-pattern scheduler: pattern advances and mono switches only
// take effect at frame boundaries, with a generator reset pulse and whole-frame blanking.
module vga_pattern_sched #(
  parameter int NPAT        = 4,
  parameter int PW          = 2,
  parameter int AUTO_FRAMES = 300,
  parameter int BLANK_FR    = 1,
  parameter int CW          = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  vga_pattern_sched_if.slave bus
);
  typedef enum logic [1:0] {RUN, PEND, BLANK} state_t;

  localparam logic [CW-1:0] AUTO_LAST  = CW'(AUTO_FRAMES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_FR - 1);
  localparam logic [PW-1:0] PAT_LAST   = PW'(NPAT - 1);

  state_t        state_reg;
  logic [PW-1:0] pattern_reg;
  logic          mono_reg;
  logic          gen_rst_reg;
  logic          blank_reg;
  logic          busy_reg;
  logic [CW-1:0] auto_cnt_reg;
  logic [CW-1:0] blank_cnt_reg;
  logic          req_q_reg;
  logic          btn_prev_reg;

  logic nxt_edge;
  logic auto_hit;
  logic req;

  assign nxt_edge = btn_prev_reg & ~bus.btn_next;
  assign auto_hit = (state_reg == RUN) & bus.auto_en & bus.frame_start &
                    (auto_cnt_reg == AUTO_LAST);
  assign req      = nxt_edge | auto_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      pattern_reg   <= '0;
      mono_reg      <= 1'b0;
      gen_rst_reg   <= 1'b0;
      blank_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      auto_cnt_reg  <= '0;
      blank_cnt_reg <= '0;
      req_q_reg     <= 1'b0;
      btn_prev_reg  <= 1'b0;
    end else begin
      btn_prev_reg <= bus.btn_next;
      gen_rst_reg  <= 1'b0;

      // Timer only runs while idle; a pattern change below overrides this with a clear.
      if (!bus.auto_en)
        auto_cnt_reg <= '0;
      else if (state_reg == RUN && bus.frame_start)
        auto_cnt_reg <= auto_hit ? '0 : auto_cnt_reg + CW'(1);

      case (state_reg)
        RUN: begin
          if (bus.frame_start)
            mono_reg <= bus.btn_mono;
          if (req) begin
            state_reg <= PEND;
            busy_reg  <= 1'b1;
          end
        end
        PEND: begin
          if (req)
            req_q_reg <= 1'b1;
          if (bus.frame_start) begin
            pattern_reg   <= (pattern_reg == PAT_LAST) ? '0 : pattern_reg + PW'(1);
            mono_reg      <= bus.btn_mono;
            gen_rst_reg   <= 1'b1;
            blank_reg     <= 1'b1;
            blank_cnt_reg <= '0;
            auto_cnt_reg  <= '0;
            state_reg     <= BLANK;
          end
        end
        BLANK: begin
          if (bus.frame_start) begin
            if (blank_cnt_reg == BLANK_LAST) begin
              blank_reg <= 1'b0;
              // A request landing on the final blank frame counts as queued.
              if (req_q_reg || req) begin
                state_reg <= PEND;
                req_q_reg <= 1'b0;
              end else begin
                state_reg <= RUN;
                busy_reg  <= 1'b0;
              end
            end else begin
              blank_cnt_reg <= blank_cnt_reg + CW'(1);
              if (req)
                req_q_reg <= 1'b1;
            end
          end else if (req) begin
            req_q_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= RUN;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pattern = pattern_reg;
  assign bus.mono    = mono_reg;
  assign bus.gen_rst = gen_rst_reg;
  assign bus.blank   = blank_reg;
  assign bus.busy    = busy_reg;
endmodule
